result_bcd_display: RTL and testbench
=====================================

// Module: result_bcd_display
// PURPOSE
//  Output end of the calculator datapath. Takes the two's-complement Result and the Overflow flag.
//  Converts them back to signed-magnitude decimal: a sign plus DIGITS BCD digits, computed with a
//  sequential double-dabble (shift/add-3) engine. Drives active-low 7-segment patterns for the HEX displays.
//  Sits between the calculator core and the board display pins.
// PARAMETERS
//  W       11  width of Value; two's complement.
//  DIGITS   4  BCD digits; must satisfy 10**DIGITS > 2**(W-1).
// PORTS
//  Clock     in   1           system clock; single clock domain.
//  ResetN    in   1           asynchronous, active-low reset.
//  Start     in   1           request a conversion; sampled only in IDLE.
//  Value     in   W           signed two's-complement number to display.
//  OvfIn     in   1           overflow flag; sampled together with Value.
//  Busy      out  1           high while a conversion is in flight.
//  Done      out  1           one-cycle pulse when outputs update.
//  Sign      out  1           1 = negative result displayed.
//  Bcd       out  4*DIGITS    BCD magnitude; digit 0 = LS nibble.
//  Seg       out  7*DIGITS    active-low {g,f,e,d,c,b,a} per digit; digit 0 = LS 7 bits.
//  SignSeg   out  7           active-low sign display.
// BEHAVIOUR
//  Reset values: Busy=0, Done=0, Sign=0, Bcd=0, Seg=all 7'h7F (blank), SignSeg=7'h7F. FSM=IDLE.
//  FSM states:
//   - IDLE -> CONV on Start.
//   - CONV -> CONV while Cnt!=0.
//   - CONV -> DONE after the W-th shift.
//   - DONE -> IDLE unconditionally.
//  Capture edge (IDLE & Start):
//   - Mag <= |Value| as a W-bit unsigned value; -2**(W-1) yields 2**(W-1), with no saturation.
//   - NegR <= Value[W-1]; OvfR <= OvfIn; scratch BCD <= 0; Cnt <= W.
//  Each CONV edge:
//   - Every scratch digit >= 5 gets +3.
//   - Then {scratch, Mag} shifts left by 1.
//   - Cnt <= Cnt-1.
//   - Exactly W CONV edges occur.
//  DONE edge:
//   - Output registers load and Done=1 for that one cycle.
//   - Done rises exactly W+2 edges after the capture edge.
//   - Busy=1 from the capture edge through the DONE cycle.
//  Output rules at DONE:
//   - Normal: Bcd = scratch; Sign = NegR & (Mag!=0).
//   - Leading-zero blanking: every digit above the most-significant nonzero digit shows 7'h7F; digit 0 always shows.
//   - SignSeg = Sign ? 7'h3F ('-') : 7'h7F.
//   - OvfR=1: Bcd = all 4'hF; Sign = 0; every Seg digit = 7'h06 ('E'); SignSeg = 7'h7F.
//  Start while Busy is ignored and not queued; Value/OvfIn changes during CONV have no effect.
//  Bcd/Sign/Seg/SignSeg hold their last values between conversions; they never show partial results.
//  Start held high: a new capture occurs on the first IDLE cycle after DONE.
//  ResetN low mid-conversion: immediate return to reset values; no Done pulse.
// STRUCTURE
//  Package calc_disp_pkg:
//   - state enum IDLE/CONV/DONE.
//   - SEG_BLANK=7'h7F, SEG_MINUS=7'h3F, SEG_E=7'h06, SEG_ZERO=7'h40.
//   - function digits_needed(W).
//  Sub-module bcd_to_7seg: combinational 4-bit -> 7-bit active-low decoder, values 0-9.
//   - Inputs 10-15 map to SEG_BLANK.
//   - Instantiated DIGITS times via generate.
//  Top holds the FSM, Cnt ($clog2(W+1) bits), the scratch shift register, and the blanking logic.
// TESTING (W=11, DIGITS=4)
//  1. Value=123, Start 1 cycle -> Done on edge 13 after capture; Bcd=16'h0123; Sign=0;
//     Seg digits 3=7'h7F, 2=7'h79 ('1'), 0=7'h30 ('3'); SignSeg=7'h7F.
//  2. Value=11'h400 (-1024) -> Bcd=16'h1024; Sign=1; SignSeg=7'h3F; no digit blanked.
//  3. Value=0 -> Bcd=0; Sign=0; digit0=7'h40; digits 3..1=7'h7F.
//     Value=-1 -> Bcd=16'h0001; Sign=1.
//  4. OvfIn=1, Value=5 -> Bcd=16'hFFFF; all Seg digits=7'h06; SignSeg=7'h7F; Sign=0.
//  5. Value=77, then at capture+4 apply Start with Value=-9 -> ignored; single Done; Bcd=16'h0077.
//     A fresh Start after Done gives Bcd=16'h0009 with Sign=1.
//  6. Value=500; ResetN low at capture+6 for 2 cycles -> Busy=0 immediately; no Done; Seg all 7'h7F.
//     Next conversion then completes normally.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared definitions for the result display path.
// Holds the conversion FSM state type, the active-low 7-segment glyph constants and a
// helper that returns how many decimal digits a W-bit two's-complement magnitude needs.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Smallest d with 10**d > 2**(w-1), i.e. enough digits for the largest magnitude.
  function automatic int unsigned digits_needed(input int unsigned w);
    longint unsigned lim;
    longint unsigned pw;
    int unsigned     d;
    lim = 64'd1 << (w - 1);
    pw  = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (pw <= lim) begin
        pw = pw * 10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   bcd_i  4-bit BCD digit; 10-15 are not digits and decode to a blank display.
//   seg_o  active-low {g,f,e,d,c,b,a}.
module bcd_to_7seg
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_ZERO;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_bcd_display.sv
// Output end of the calculator datapath: converts a two's-complement result plus overflow flag
// into sign + BCD magnitude using a sequential double-dabble engine, and drives active-low
// 7-segment patterns with leading-zero blanking.
// Ports:
//   Clock    system clock
//   ResetN   asynchronous active-low reset
//   Start    conversion request, only honoured while the FSM is idle
//   Value    signed W-bit value to display
//   OvfIn    overflow flag, captured with Value
//   Busy     high from the capture edge through the Done cycle
//   Done     one-cycle pulse when the display outputs update
//   Sign     1 when a negative, nonzero result is shown
//   Bcd      BCD magnitude, digit 0 in the LS nibble (all 4'hF on overflow)
//   Seg      active-low segments per digit, digit 0 in the LS 7 bits
//   SignSeg  active-low sign digit ('-' or blank)
module result_bcd_display
  import calc_disp_pkg::*;
#(
  parameter int unsigned W      = 11,
  parameter int unsigned DIGITS = 4
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Start,
  input  logic [W-1:0]        Value,
  input  logic                OvfIn,
  output logic                Busy,
  output logic                Done,
  output logic                Sign,
  output logic [4*DIGITS-1:0] Bcd,
  output logic [7*DIGITS-1:0] Seg,
  output logic [6:0]          SignSeg
);

  localparam int unsigned     CntW    = $clog2(W + 1);
  localparam int unsigned     BcdW    = 4 * DIGITS;
  localparam logic [CntW-1:0] CntInit = CntW'(W);

  if (DIGITS < digits_needed(W)) begin : gen_digits_check
    $error("DIGITS too small to hold the magnitude of a W-bit value");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]        mag_q, mag_d;
  logic [BcdW-1:0]     scratch_q, scratch_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                sign_q, sign_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [6:0]          sign_seg_q, sign_seg_d;

  logic [W-1:0]        value_abs;
  logic [BcdW-1:0]     scratch_adj;
  logic [7*DIGITS-1:0] dec_seg;
  logic [7*DIGITS-1:0] seg_norm;
  logic                sign_nxt;

  // -2**(W-1) wraps to 2**(W-1) as an unsigned W-bit value, which is the wanted magnitude.
  assign value_abs = Value[W-1] ? (~Value + {{(W-1){1'b0}}, 1'b1}) : Value;

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_dec
    bcd_to_7seg u_dec (
      .bcd_i (scratch_q[4*g +: 4]),
      .seg_o (dec_seg[7*g +: 7])
    );
  end

  // Leading-zero blanking, scanning from the top digit down; digit 0 is never blanked.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    seg_norm = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (scratch_q[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      if (seen || (i == 0)) begin
        seg_norm[7*i +: 7] = dec_seg[7*i +: 7];
      end else begin
        seg_norm[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  // A negative input always has a nonzero magnitude, but keep the guard explicit.
  assign sign_nxt = ~ovf_q & neg_q & (|scratch_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    seg_d      = seg_q;
    sign_seg_d = sign_seg_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d   = StConv;
          mag_d     = value_abs;
          neg_d     = Value[W-1];
          ovf_d     = OvfIn;
          scratch_d = '0;
          cnt_d     = CntInit;
        end
      end
      StConv: begin
        if (cnt_q != '0) begin
          {scratch_d, mag_d} = {scratch_adj, mag_q} << 1;
          cnt_d              = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        sign_d     = sign_nxt;
        bcd_d      = ovf_q ? {BcdW{1'b1}} : scratch_q;
        seg_d      = ovf_q ? {DIGITS{SEG_E}} : seg_norm;
        sign_seg_d = sign_nxt ? SEG_MINUS : SEG_BLANK;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mag_q      <= '0;
      scratch_q  <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= {DIGITS{SEG_BLANK}};
      sign_seg_q <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
      sign_seg_q <= sign_seg_d;
    end
  end

  // Busy also covers the Done cycle, where the FSM is already back in idle.
  assign Busy    = (state_q != StIdle) | done_q;
  assign Done    = done_q;
  assign Sign    = sign_q;
  assign Bcd     = bcd_q;
  assign Seg     = seg_q;
  assign SignSeg = sign_seg_q;

endmodule

// File: tb/tb_result_bcd_display.sv
module tb_result_bcd_display;

  localparam int W      = 11;
  localparam int DIGITS = 4;
  localparam int LAT    = W + 2;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
    logic [7*DIGITS-1:0] seg;
    logic [6:0]          sseg;
    int                  done_cyc;
  } exp_t;

  logic                Clock = 1'b0;
  logic                ResetN = 1'b0;
  logic                Start = 1'b0;
  logic [W-1:0]        Value = '0;
  logic                OvfIn = 1'b0;
  logic                Busy;
  logic                Done;
  logic                Sign;
  logic [4*DIGITS-1:0] Bcd;
  logic [7*DIGITS-1:0] Seg;
  logic [6:0]          SignSeg;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  result_bcd_display #(.W(W), .DIGITS(DIGITS)) dut (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .Start   (Start),
    .Value   (Value),
    .OvfIn   (OvfIn),
    .Busy    (Busy),
    .Done    (Done),
    .Sign    (Sign),
    .Bcd     (Bcd),
    .Seg     (Seg),
    .SignSeg (SignSeg)
  );

  initial forever #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference: digits by division, blanking by position of the top nonzero digit.
  function automatic exp_t model(input int v, input bit ovf);
    exp_t e;
    int   mag, d, top;
    e.bcd  = '0;
    e.seg  = '0;
    e.done_cyc = 0;
    if (ovf) begin
      e.bcd  = '1;
      e.sign = 1'b0;
      for (int i = 0; i < DIGITS; i++) e.seg[7*i +: 7] = 7'h06;
      e.sseg = 7'h7F;
      return e;
    end
    mag = (v < 0) ? -v : v;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = (mag / (10 ** i)) % 10;
      e.bcd[4*i +: 4] = 4'(d);
      if (d != 0) top = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      d = (mag / (10 ** i)) % 10;
      e.seg[7*i +: 7] = (i <= top) ? seg_tab[d] : 7'h7F;
    end
    e.sign = (v < 0);
    e.sseg = e.sign ? 7'h3F : 7'h7F;
    return e;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (ResetN && Done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got Done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_latency", 64'(cyc), 64'(mon_e.done_cyc));
        check("bcd", 64'(Bcd), 64'(mon_e.bcd));
        check("sign", 64'(Sign), 64'(mon_e.sign));
        check("seg", 64'(Seg), 64'(mon_e.seg));
        check("sign_seg", 64'(SignSeg), 64'(mon_e.sseg));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && Busy; i++) @(negedge Clock);
    if (Busy) check("idle_timeout", 64'(Busy), 64'd0);
  endtask

  task automatic issue(input int v, input bit ovf, output int cap);
    exp_t e;
    wait_idle();
    @(negedge Clock);
    Value = W'(v);
    OvfIn = ovf;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    cap = cyc;
    e = model(v, ovf);
    e.done_cyc = cap + LAT;
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    Value = W'($urandom);
    OvfIn = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge Clock);
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge Clock);
  endtask

  initial begin
    int   cap;
    int   v;
    exp_t e;

    repeat (3) @(negedge Clock);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_bcd", 64'(Bcd), 64'd0);
    check("rst_seg", 64'(Seg), 64'hFFFFFFF);
    check("rst_sign_seg", 64'(SignSeg), 64'h7F);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);

    issue(123, 1'b0, cap);   drain();
    issue(-1024, 1'b0, cap); drain();
    issue(0, 1'b0, cap);     drain();
    issue(-1, 1'b0, cap);    drain();
    issue(5, 1'b1, cap);     drain();
    issue(1023, 1'b0, cap);  drain();

    // Start while busy is dropped, not queued.
    issue(77, 1'b0, cap);
    while (cyc < cap + 4) @(negedge Clock);
    check("busy_mid_conv", 64'(Busy), 64'd1);
    Value = W'(-9);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    drain();
    repeat (5) @(negedge Clock);
    issue(-9, 1'b0, cap); drain();

    // Start held high: recapture on the first idle cycle after DONE.
    wait_idle();
    @(negedge Clock);
    Value = W'(321);
    OvfIn = 1'b0;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    cap = cyc;
    e = model(321, 1'b0);
    e.done_cyc = cap + LAT;
    sb.push_back(e);
    e.done_cyc = cap + LAT + LAT + 1;
    sb.push_back(e);
    while (cyc < cap + LAT + 1) @(negedge Clock);
    Start = 1'b0;
    drain();

    // Reset in the middle of a conversion: no Done, outputs back to reset values.
    wait_idle();
    @(negedge Clock);
    Value = W'(500);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    cap = cyc;
    @(negedge Clock);
    Start = 1'b0;
    while (cyc < cap + 6) @(posedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_seg", 64'(Seg), 64'hFFFFFFF);
    check("rst_mid_bcd", 64'(Bcd), 64'd0);
    check("rst_mid_sign_seg", 64'(SignSeg), 64'h7F);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    repeat (20) @(negedge Clock);
    issue(500, 1'b0, cap); drain();

    for (int k = 0; k < 30; k++) begin
      v = int'($urandom_range(0, 2047));
      if (v >= 1024) v = v - 2048;
      issue(v, ($urandom_range(0, 5) == 0), cap);
      drain();
    end

    repeat (5) @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
